// File: rtl/hub75_pixel_fetch_if.sv
// ---------------------------------------------------------------------------
// hub75_pixel_fetch_if
//   Bundles the three buses of the HUB75 pixel fetcher:
//     framebuffer read port : fb_rd, fb_addr, fb_rdata
//     buffer swap handshake : swap_req, swap_ack
//     column stream         : px_valid, px_ready, px_rgb0, px_rgb1,
//                             px_row, px_plane, px_last
//   modport master : the fetcher (drives fb_rd/fb_addr, swap_ack, px_*)
//   modport slave  : the environment (RAM, swap requester, LED driver)
//   Parameters must match the ones given to hub75_pixel_fetch.
// ---------------------------------------------------------------------------
interface hub75_pixel_fetch_if #(
    parameter int COLS      = 64,
    parameter int ROW_ADDRS = 32,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROW_ADDRS);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = 1 + RW + 1 + CW;

    logic                 fb_rd;
    logic [AW-1:0]        fb_addr;
    logic [3*DEPTH-1:0]   fb_rdata;
    logic                 swap_req;
    logic                 swap_ack;
    logic                 px_valid;
    logic                 px_ready;
    logic [2:0]           px_rgb0;
    logic [2:0]           px_rgb1;
    logic [RW-1:0]        px_row;
    logic [PW-1:0]        px_plane;
    logic                 px_last;

    modport master (
        output fb_rd, fb_addr,
        input  fb_rdata,
        input  swap_req,
        output swap_ack,
        output px_valid,
        input  px_ready,
        output px_rgb0, px_rgb1, px_row, px_plane, px_last
    );

    modport slave (
        input  fb_rd, fb_addr,
        output fb_rdata,
        output swap_req,
        input  swap_ack,
        input  px_valid,
        output px_ready,
        input  px_rgb0, px_rgb1, px_row, px_plane, px_last
    );
endinterface

// File: rtl/hub75_pixel_fetch.sv
// ---------------------------------------------------------------------------
// hub75_pixel_fetch
//   Pixel source for a HUB75 LED driver. Scans a double-buffered RGB444
//   framebuffer in bit-plane / row / column order. For each column it reads
//   the top-half pixel (y = row) and the bottom-half pixel
//   (y = row + ROW_ADDRS), selects the current bit-plane of each channel and
//   hands one {B,G,R} bit pair per column to the driver over valid/ready.
//
// Ports
//   clk      : clock
//   reset    : synchronous, active-high
//   bus      : hub75_pixel_fetch_if.master
//     fb_rd / fb_addr {buf_sel, y[RW:0], x[CW-1:0]} / fb_rdata {B,G,R}
//                 (fb_rdata valid one cycle after fb_rd)
//     swap_req (pulse in) / swap_ack (pulse out when the buffer flips)
//     px_valid / px_ready / px_rgb0 (top) / px_rgb1 (bottom) /
//     px_row / px_plane / px_last (column == COLS-1)
//
// Build option
//   HUB75_GAMMA_EN : when defined, each 4-bit channel is passed through a
//                    fixed gamma LUT before the bit-plane select (DEPTH must
//                    be 4). When undefined the channels are used linearly.
// ---------------------------------------------------------------------------
module hub75_pixel_fetch #(
    parameter int COLS      = 64,
    parameter int ROW_ADDRS = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    hub75_pixel_fetch_if.master  bus
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROW_ADDRS);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = 3 * DEPTH;

    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROW_ADDRS - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(DEPTH - 1);

    localparam logic [1:0] S_RD_TOP = 2'd0;
    localparam logic [1:0] S_RD_BOT = 2'd1;
    localparam logic [1:0] S_CAPT   = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

`ifdef HUB75_GAMMA_EN
    if (DEPTH != 4) begin : g_depth_check
        $error("hub75_pixel_fetch: HUB75_GAMMA_EN requires DEPTH == 4");
    end

    function automatic logic [3:0] gamma4(input logic [3:0] v);
        logic [3:0] m;
        m = '0;
        case (v)
            4'd0:  m = 4'd0;
            4'd1:  m = 4'd0;
            4'd2:  m = 4'd0;
            4'd3:  m = 4'd1;
            4'd4:  m = 4'd1;
            4'd5:  m = 4'd1;
            4'd6:  m = 4'd2;
            4'd7:  m = 4'd2;
            4'd8:  m = 4'd3;
            4'd9:  m = 4'd4;
            4'd10: m = 4'd5;
            4'd11: m = 4'd6;
            4'd12: m = 4'd8;
            4'd13: m = 4'd10;
            4'd14: m = 4'd12;
            4'd15: m = 4'd15;
            default: m = 4'd0;
        endcase
        return m;
    endfunction
`endif

    // {B,G,R} bit of the selected plane for one packed pixel.
    function automatic logic [2:0] plane_bits(input logic [DW-1:0] pix,
                                              input logic [PW-1:0] pl);
        logic [DEPTH-1:0] r;
        logic [DEPTH-1:0] g;
        logic [DEPTH-1:0] b;
        r = pix[0       +: DEPTH];
        g = pix[DEPTH   +: DEPTH];
        b = pix[2*DEPTH +: DEPTH];
`ifdef HUB75_GAMMA_EN
        r = gamma4(r);
        g = gamma4(g);
        b = gamma4(b);
`endif
        return {b[pl], g[pl], r[pl]};
    endfunction

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] plane;
    logic          buf_sel;
    logic          swap_pending;
    logic [DW-1:0] top_pix;

    logic          px_valid_q;
    logic [2:0]    px_rgb0_q;
    logic [2:0]    px_rgb1_q;
    logic [RW-1:0] px_row_q;
    logic [PW-1:0] px_plane_q;
    logic          px_last_q;
    logic          swap_ack_q;

    logic          rd_phase;
    logic          frame_end;

    // The read strobe is decoded from the state but gated by reset so the
    // port is quiet for the whole time reset is held.
    always_comb begin
        rd_phase  = !reset && ((state == S_RD_TOP) || (state == S_RD_BOT));
        frame_end = (col == COL_LAST) && (row == ROW_LAST) && (plane == PLANE_LAST);
    end

    assign bus.fb_rd    = rd_phase;
    assign bus.fb_addr  = rd_phase ? {buf_sel, (state == S_RD_BOT), row, col} : '0;
    assign bus.px_valid = px_valid_q;
    assign bus.px_rgb0  = px_rgb0_q;
    assign bus.px_rgb1  = px_rgb1_q;
    assign bus.px_row   = px_row_q;
    assign bus.px_plane = px_plane_q;
    assign bus.px_last  = px_last_q;
    assign bus.swap_ack = swap_ack_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RD_TOP;
            col          <= '0;
            row          <= '0;
            plane        <= '0;
            buf_sel      <= 1'b0;
            swap_pending <= 1'b0;
            top_pix      <= '0;
            px_valid_q   <= 1'b0;
            px_rgb0_q    <= '0;
            px_rgb1_q    <= '0;
            px_row_q     <= '0;
            px_plane_q   <= '0;
            px_last_q    <= 1'b0;
            swap_ack_q   <= 1'b0;
        end else begin
            swap_ack_q <= 1'b0;
            if (bus.swap_req) begin
                swap_pending <= 1'b1;
            end

            case (state)
                S_RD_TOP: begin
                    state <= S_RD_BOT;
                end
                S_RD_BOT: begin
                    top_pix <= bus.fb_rdata;
                    state   <= S_CAPT;
                end
                S_CAPT: begin
                    // Bottom pixel is consumed straight off the read data.
                    px_rgb0_q  <= plane_bits(top_pix, plane);
                    px_rgb1_q  <= plane_bits(bus.fb_rdata, plane);
                    px_row_q   <= row;
                    px_plane_q <= plane;
                    px_last_q  <= (col == COL_LAST);
                    px_valid_q <= 1'b1;
                    state      <= S_OUT;
                end
                default: begin
                    if (bus.px_ready) begin
                        px_valid_q <= 1'b0;
                        state      <= S_RD_TOP;

                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row <= '0;
                                if (plane == PLANE_LAST) begin
                                    plane <= '0;
                                end else begin
                                    plane <= plane + PW'(1);
                                end
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end

                        // Buffer flips only between frames; a request arriving
                        // on the final transfer still counts for this boundary.
                        if (frame_end && (swap_pending || bus.swap_req)) begin
                            buf_sel      <= ~buf_sel;
                            swap_pending <= 1'b0;
                            swap_ack_q   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_pixel_fetch.sv
module tb_hub75_pixel_fetch;
    localparam int COLS  = 64;
    localparam int RA    = 32;
    localparam int DEPTH = 4;
    localparam int FRAME = COLS * RA * DEPTH;
    localparam int HALF  = RA * COLS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hub75_pixel_fetch_if #(.COLS(COLS), .ROW_ADDRS(RA), .DEPTH(DEPTH)) bus ();

    hub75_pixel_fetch #(.COLS(COLS), .ROW_ADDRS(RA), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM, both buffers, one-cycle read latency.
    logic [11:0] mem [0:8191];
    always @(posedge clk) begin
        if (bus.fb_rd) bus.fb_rdata <= mem[bus.fb_addr];
    end

`ifdef HUB75_GAMMA_EN
    localparam logic [3:0] GAMMA [16] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
                                          4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15};
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_bits(input logic [11:0] p, input int pl);
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        r = p[3:0];
        g = p[7:4];
        b = p[11:8];
`ifdef HUB75_GAMMA_EN
        r = GAMMA[r];
        g = GAMMA[g];
        b = GAMMA[b];
`endif
        return {b[pl], g[pl], r[pl]};
    endfunction

    // ---------------- behavioural model + compare ----------------
    int   n = 0;          // transfer index within the frame
    int   phase = 0;      // 0 top read, 1 bottom read, 2 capture gap, 3 column offered
    int   m_buf = 0;
    bit   m_pending = 0;
    bit   ack_exp = 0;
    bit   prev_rst = 0;
    int   ack_count = 0;
    int   xfer_count = 0;
    int   last_count = 0;
    bit   cap_en = 0;
    logic [2:0] cap_top [4][3];
    logic [2:0] cap_bot [4];

    always @(negedge clk) begin : cmp
        int  col;
        int  row;
        int  plane;
        int  top;
        bit  pend_now;
        if (reset) begin
            if (prev_rst) begin
                chk("rst_fb_rd", 32'(bus.fb_rd), 0);
                chk("rst_fb_addr", 32'(bus.fb_addr), 0);
                chk("rst_px_valid", 32'(bus.px_valid), 0);
                chk("rst_swap_ack", 32'(bus.swap_ack), 0);
                chk("rst_px_rgb", {26'd0, bus.px_rgb0, bus.px_rgb1}, 0);
                chk("rst_px_row", 32'(bus.px_row), 0);
                chk("rst_px_plane", 32'(bus.px_plane), 0);
                chk("rst_px_last", 32'(bus.px_last), 0);
            end
            n = 0; phase = 0; m_buf = 0; m_pending = 0; ack_exp = 0;
        end else begin
            chk("swap_ack", 32'(bus.swap_ack), 32'(ack_exp));
            if (bus.swap_ack) ack_count++;
            ack_exp = 0;
            col   = n % COLS;
            row   = (n / COLS) % RA;
            plane = n / (COLS * RA);
            top   = m_buf * 4096 + row * COLS + col;
            pend_now  = m_pending || bus.swap_req;
            m_pending = pend_now;
            case (phase)
                0: begin
                    chk("rd_top", 32'(bus.fb_rd), 1);
                    chk("addr_top", 32'(bus.fb_addr), 32'(top));
                    chk("valid_in_read", 32'(bus.px_valid), 0);
                    phase = 1;
                end
                1: begin
                    chk("rd_bot", 32'(bus.fb_rd), 1);
                    chk("addr_bot", 32'(bus.fb_addr), 32'(top + HALF));
                    chk("valid_in_read", 32'(bus.px_valid), 0);
                    phase = 2;
                end
                2: begin
                    chk("rd_in_capt", 32'(bus.fb_rd), 0);
                    chk("valid_in_capt", 32'(bus.px_valid), 0);
                    phase = 3;
                end
                default: begin
                    chk("rd_while_valid", 32'(bus.fb_rd), 0);
                    chk("px_valid", 32'(bus.px_valid), 1);
                    chk("px_rgb0", 32'(bus.px_rgb0), 32'(exp_bits(mem[top], plane)));
                    chk("px_rgb1", 32'(bus.px_rgb1), 32'(exp_bits(mem[top + HALF], plane)));
                    chk("px_row", 32'(bus.px_row), 32'(row));
                    chk("px_plane", 32'(bus.px_plane), 32'(plane));
                    chk("px_last", 32'(bus.px_last), 32'(col == COLS - 1));
                    if (bus.px_ready) begin
                        xfer_count++;
                        if (col == COLS - 1) last_count++;
                        if (cap_en && row == 0 && col < 3) begin
                            cap_top[plane][col] = bus.px_rgb0;
                            if (col == 0) cap_bot[plane] = bus.px_rgb1;
                        end
                        if (n == FRAME - 1 && pend_now) begin
                            ack_exp   = 1;
                            m_buf     = 1 - m_buf;
                            m_pending = 0;
                        end
                        n = (n + 1) % FRAME;
                        phase = 0;
                    end
                end
            endcase
        end
        prev_rst = reset;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int addrs [4];
        int na;
        int first_valid;
        int guard;
        int rd_seen;
        logic [2:0] e_top [4][3];
        logic [2:0] e_bot [4];

        for (int a = 0; a < 8192; a++) mem[a] = 12'(a);
        mem[0]    = 12'hF0A;   // col 0 row 0 top
        mem[2048] = 12'h005;   // col 0 row 0 bottom
        mem[1]    = 12'h0AA;   // col 1 row 0 top
        mem[2]    = 12'h008;   // col 2 row 0 top

`ifdef HUB75_GAMMA_EN
        e_top = '{'{3'd5, 3'd3, 3'd1}, '{3'd4, 3'd0, 3'd1}, '{3'd5, 3'd3, 3'd0}, '{3'd4, 3'd0, 3'd0}};
        e_bot = '{3'd1, 3'd0, 3'd0, 3'd0};
`else
        e_top = '{'{3'd4, 3'd0, 3'd0}, '{3'd5, 3'd3, 3'd0}, '{3'd4, 3'd0, 3'd0}, '{3'd5, 3'd3, 3'd1}};
        e_bot = '{3'd1, 3'd0, 3'd1, 3'd0};
`endif

        bus.px_ready = 1'b1;
        bus.swap_req = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // First reads and first-valid latency.
        na = 0;
        first_valid = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (bus.fb_rd && na < 4) begin
                addrs[na] = int'(bus.fb_addr);
                na++;
            end
            if (bus.px_valid && first_valid < 0) first_valid = cyc;
        end
        chk("first_valid_cycle", 32'(first_valid), 3);
        chk("read_count", 32'(na), 4);
        chk("addr0", 32'(addrs[0]), 0);
        chk("addr1", 32'(addrs[1]), 2048);
        chk("addr2", 32'(addrs[2]), 1);
        chk("addr3", 32'(addrs[3]), 2049);

        // Back-pressure: hold px_ready low for 10 cycles with a column offered.
        guard = 0;
        @(posedge clk); #1;
        while (!bus.px_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("stall_valid_seen", 32'(bus.px_valid), 1);
        bus.px_ready = 1'b0;
        rd_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.fb_rd) rd_seen++;
        end
        chk("stall_no_fb_rd", 32'(rd_seen), 0);
        chk("stall_valid_held", 32'(bus.px_valid), 1);
        @(posedge clk); #1 bus.px_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("fb_rd_after_accept", 32'(bus.fb_rd), 1);

        // Reset during the bottom read with a swap pending.
        @(posedge clk); #1 bus.swap_req = 1'b1;
        @(posedge clk); #1 bus.swap_req = 1'b0;
        guard = 0;
        while (!(bus.fb_rd && bus.fb_addr[11]) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("bot_read_seen", 32'(bus.fb_rd && bus.fb_addr[11]), 1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        xfer_count = 0;
        last_count = 0;
        ack_count  = 0;
        cap_en     = 1;
        #1 reset = 1'b0;
        @(negedge clk);
        chk("restart_rd", 32'(bus.fb_rd), 1);
        chk("restart_addr", 32'(bus.fb_addr), 0);

        // Frame A: full frame, no swap requested.
        guard = 0;
        while (xfer_count < FRAME && guard < 4 * FRAME + 100) begin
            @(negedge clk);
            guard++;
        end
        cap_en = 0;
        chk("frameA_transfers", 32'(xfer_count), 8192);
        chk("frameA_last_count", 32'(last_count), 128);
        chk("frameA_no_ack", 32'(ack_count), 0);
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 3; c++) chk($sformatf("top_p%0d_c%0d", p, c), 32'(cap_top[p][c]), 32'(e_top[p][c]));
            chk($sformatf("bot_p%0d_c0", p), 32'(cap_bot[p]), 32'(e_bot[p]));
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.px_valid && guard < 10);
        chk("wrap_row", 32'(bus.px_row), 0);
        chk("wrap_plane", 32'(bus.px_plane), 0);
        chk("wrap_last", 32'(bus.px_last), 0);

        // Frame B: swap request mid-frame and again on the final transfer.
        guard = 0;
        while (xfer_count < FRAME + 1000 && guard < 8000) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1 bus.swap_req = 1'b1;
        @(posedge clk); #1 bus.swap_req = 1'b0;
        guard = 0;
        while (!(bus.px_valid && bus.px_last && bus.px_row == 5'd31 && bus.px_plane == 2'd3)
               && guard < 40000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("final_column_seen", 32'(bus.px_valid && bus.px_last), 1);
        chk("ack_before_last", 32'(ack_count), 0);
        bus.swap_req = 1'b1;
        @(posedge clk); #1 bus.swap_req = 1'b0;
        @(negedge clk);
        chk("ack_after_last", 32'(bus.swap_ack), 1);
        chk("rd_after_swap", 32'(bus.fb_rd), 1);
        chk("buf_msb_after_swap", 32'(bus.fb_addr[12]), 1);
        repeat (40) @(negedge clk);
        chk("single_ack", 32'(ack_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
